// File: rtl/sliding_window_adder_if.sv
// Sliding window adder bus: sample input, control and result signals.
// Ports: master drives in_valid/in_data/clear/avg_mode, slave drives outp/out_valid/fill/full.
interface sliding_window_adder_if #(
    parameter int data_width = 4,
    parameter int N          = 2
);
    logic                    in_valid;
    logic [data_width-1:0]   in_data;
    logic                    clear;
    logic                    avg_mode;
    logic                    out_valid;
    logic [data_width+N-1:0] outp;
    logic [N:0]              fill;
    logic                    full;

    modport master (
        output in_valid, in_data, clear, avg_mode,
        input  out_valid, outp, fill, full
    );

    modport slave (
        input  in_valid, in_data, clear, avg_mode,
        output out_valid, outp, fill, full
    );
endinterface

// File: rtl/sliding_window_adder.sv
// Running sum / average over the last 2^N accepted samples.
// Ports: clk, rst (async active-high), bus (slave modport of sliding_window_adder_if).
module sliding_window_adder #(
    parameter int data_width = 4,
    parameter int N          = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    sliding_window_adder_if.slave bus
);
    localparam int         W      = 1 << N;
    localparam int         SW     = data_width + N;
    localparam logic [N:0] FILL_W = (N+1)'(W);

    logic [data_width-1:0] r_buf [W];
    logic [N-1:0]          r_ptr;
    logic [SW-1:0]         r_sum;
    logic [N:0]            r_fill;
    logic [SW-1:0]         r_outp;
    logic                  r_out_valid;

    logic                  w_accept;
    logic                  w_full;
    logic [data_width-1:0] w_old;
    logic [SW-1:0]         w_sum_next;
    logic [SW-1:0]         w_avg;

    assign w_accept = bus.in_valid & ~bus.clear;
    assign w_full   = (r_fill == FILL_W);

    // Entries are only subtracted once the window is full, so stale
    // buffer contents from before a reset/clear are never observed.
    assign w_old      = w_full ? r_buf[r_ptr] : '0;
    assign w_sum_next = r_sum + SW'(bus.in_data) - SW'(w_old);
    assign w_avg      = w_sum_next >> N;

    always_ff @(posedge clk) begin
        if (w_accept)
            r_buf[r_ptr] <= bus.in_data;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr       <= '0;
            r_sum       <= '0;
            r_fill      <= '0;
            r_outp      <= '0;
            r_out_valid <= 1'b0;
        end else if (bus.clear) begin
            r_ptr       <= '0;
            r_sum       <= '0;
            r_fill      <= '0;
            r_outp      <= '0;
            r_out_valid <= 1'b0;
        end else if (w_accept) begin
            r_ptr       <= r_ptr + 1'b1;
            r_sum       <= w_sum_next;
            r_outp      <= bus.avg_mode ? w_avg : w_sum_next;
            r_out_valid <= 1'b1;
            if (!w_full)
                r_fill <= r_fill + 1'b1;
        end else begin
            r_out_valid <= 1'b0;
        end
    end

    assign bus.outp      = r_outp;
    assign bus.out_valid = r_out_valid;
    assign bus.fill      = r_fill;
    assign bus.full      = w_full;
endmodule

// File: tb/tb_sliding_window_adder.sv
// Directed self-checking bench for sliding_window_adder (data_width=4, N=2).
// Ports: none; drives the DUT through a sliding_window_adder_if instance.
module tb_sliding_window_adder;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    sliding_window_adder_if #(.data_width(4), .N(2)) bus ();

    sliding_window_adder #(.data_width(4), .N(2)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Drive one cycle of inputs at negedge, sample 1 time unit after posedge.
    task automatic step(input logic v, input logic [3:0] d,
                        input logic c, input logic a);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_data  = d;
        bus.clear    = c;
        bus.avg_mode = a;
        @(posedge clk);
        #1;
    endtask

    task automatic expect_out(input string tag, input logic ov,
                              input int o, input int f, input logic fu);
        chk({tag, ".out_valid"}, 32'(ov), 32'(ov));
        chk({tag, ".out_valid"}, 32'(bus.out_valid), 32'(ov));
        chk({tag, ".outp"}, 32'(bus.outp), o);
        chk({tag, ".fill"}, 32'(bus.fill), f);
        chk({tag, ".full"}, 32'(bus.full), 32'(fu));
    endtask

    initial begin
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.clear    = 1'b0;
        bus.avg_mode = 1'b0;

        // Async reset before any clock edge
        #1 rst = 1'b1;
        #1;
        expect_out("reset", 1'b0, 0, 0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        // Fill window 1,2,3,4
        step(1, 4'd1, 0, 0); expect_out("acc1", 1, 1, 1, 0);
        step(1, 4'd2, 0, 0); expect_out("acc2", 1, 3, 2, 0);
        step(1, 4'd3, 0, 0); expect_out("acc3", 1, 6, 3, 0);
        step(1, 4'd4, 0, 0); expect_out("acc4", 1, 10, 4, 1);

        // Wrap-around
        step(1, 4'd5, 0, 0); expect_out("wrap5", 1, 14, 4, 1);
        step(1, 4'd6, 0, 0); expect_out("wrap6", 1, 18, 4, 1);

        // Max values, no overflow
        step(1, 4'd15, 0, 0); expect_out("max1", 1, 30, 4, 1);
        step(1, 4'd15, 0, 0); expect_out("max2", 1, 41, 4, 1);
        step(1, 4'd15, 0, 0); expect_out("max3", 1, 51, 4, 1);
        step(1, 4'd15, 0, 0); expect_out("max4", 1, 60, 4, 1);
        step(1, 4'd15, 0, 0); expect_out("max5", 1, 60, 4, 1);
        step(1, 4'd15, 0, 1); expect_out("avg60", 1, 15, 4, 1);

        // Clear beats concurrent sample on a full window
        step(1, 4'd9, 1, 0); expect_out("clear", 0, 0, 0, 0);
        step(1, 4'd2, 0, 0); expect_out("post_clr", 1, 2, 1, 0);

        // Accept 7, idle 3 cycles, accept 1
        step(0, 4'd0, 1, 0); expect_out("clear2", 0, 0, 0, 0);
        step(1, 4'd7, 0, 0); expect_out("acc7", 1, 7, 1, 0);
        step(0, 4'd3, 0, 0); expect_out("idle1", 0, 7, 1, 0);
        step(0, 4'd3, 0, 1); expect_out("idle2", 0, 7, 1, 0);
        step(0, 4'd3, 0, 0); expect_out("idle3", 0, 7, 1, 0);
        step(1, 4'd1, 0, 0); expect_out("acc1b", 1, 8, 2, 0);
        step(1, 4'd2, 0, 0); expect_out("acc2b", 1, 10, 3, 0);
        step(1, 4'd4, 0, 0); expect_out("acc4b", 1, 14, 4, 1);

        // Async reset pulse mid-stream, between clock edges
        @(negedge clk);
        bus.in_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        expect_out("rst_mid", 0, 0, 0, 0);
        #1 rst = 1'b0;
        step(1, 4'd2, 0, 0); expect_out("post_rst", 1, 2, 1, 0);

        // Partial window average: (2+6)>>2
        step(1, 4'd6, 0, 1); expect_out("avg_part", 1, 2, 2, 0);
        // Sum 8+11=19 -> avg 4
        step(1, 4'd11, 0, 1); expect_out("avg_part2", 1, 4, 3, 0);

        step(0, 4'd0, 0, 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
